// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
// Size encodings, FSM state and the read-modify-write buffer.
package dmem_pkg;

    localparam int DMEM_DEPTH = 512;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_ILL  = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0] old;
        logic [1:0]  lane;
        logic [1:0]  size;
        logic [15:0] data;
        logic        port_b;
    } rmw_t;

endpackage

// File: rtl/dmem_lane.sv
// Byte/halfword lane logic: load extraction or store merge.
// Purely combinational; merge_i selects which result is driven.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic        merge_i,
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);

    function automatic logic [31:0] extract(
        input logic [31:0] w,
        input logic [1:0]  l,
        input logic [1:0]  sz,
        input logic        u
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{l, 3'b000} +: 8];
        h = l[1] ? w[31:16] : w[15:0];
        case (sz)
            SZ_BYTE: return {{24{b[7] & ~u}}, b};
            SZ_HALF: return {{16{h[15] & ~u}}, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] merge(
        input logic [31:0] w,
        input logic [1:0]  l,
        input logic [1:0]  sz,
        input logic [31:0] d
    );
        logic [31:0] r;
        r = w;
        case (sz)
            SZ_BYTE: r[{l, 3'b000} +: 8] = d[7:0];
            SZ_HALF: r[{l[1], 4'b0000} +: 16] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    always_comb begin
        data_o = '0;
        if (merge_i) begin
            data_o = merge(word_i, lane_i, size_i, data_i);
        end else begin
            data_o = extract(word_i, lane_i, size_i, uns_i);
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Arbiter and sequencer sharing one word memory between CPU (A) and debug (B).
// Sub-word stores become a two-cycle read-modify-write.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [1:0]    a_size,
    input  logic          a_unsigned,
    input  logic [31:0]   a_addr,
    input  logic [31:0]   a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [31:0]   a_rdata,
    output logic          a_err,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [31:0]   b_addr,
    input  logic [31:0]   b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [31:0]   b_rdata,
    output logic          b_err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

    state_e        state_q, state_d;
    logic          ptr_q, ptr_d;
    rmw_t          rmw_q, rmw_d;
    logic [AW-1:0] waddr_q, waddr_d;

    logic          a_rvalid_q, a_err_q;
    logic          b_rvalid_q, b_err_q;
    logic [31:0]   a_rdata_q, b_rdata_q;

    logic          idle, acc, bad, is_sub, rmw_act;
    logic          sel_we, sel_uns;
    logic [1:0]    sel_size;
    logic [31:0]   sel_addr, sel_wdata;
    logic [31:0]   ld_data, mg_data;

    logic          rsp_v, rsp_b, rsp_err;
    logic [31:0]   rsp_data;

    // ptr_q high means B was granted last, so A wins a tie
    assign idle  = (state_q == ST_IDLE) && !rst;
    assign a_gnt = idle && a_req && (!b_req || ptr_q);
    assign b_gnt = idle && b_req && !a_gnt;
    assign acc   = a_gnt || b_gnt;

    assign rmw_act = (state_q == ST_RMW_WR) && !rst;

    assign sel_we    = b_gnt ? b_we : a_we;
    assign sel_size  = b_gnt ? SZ_WORD : a_size;
    assign sel_uns   = !b_gnt && a_unsigned;
    assign sel_addr  = b_gnt ? b_addr : a_addr;
    assign sel_wdata = b_gnt ? b_wdata : a_wdata;

    assign bad = (sel_size == SZ_ILL)
              || (sel_size == SZ_HALF && sel_addr[0])
              || (sel_size == SZ_WORD && sel_addr[1:0] != 2'b00)
              || (sel_addr >= LIMIT);

    assign is_sub = sel_we && (sel_size != SZ_WORD);

    dmem_lane u_ld_lane (
        .merge_i (1'b0),
        .word_i  (mem_rdata),
        .lane_i  (sel_addr[1:0]),
        .size_i  (sel_size),
        .uns_i   (sel_uns),
        .data_i  (32'h0),
        .data_o  (ld_data)
    );

    dmem_lane u_rmw_lane (
        .merge_i (1'b1),
        .word_i  (rmw_q.old),
        .lane_i  (rmw_q.lane),
        .size_i  (rmw_q.size),
        .uns_i   (1'b0),
        .data_i  ({16'h0, rmw_q.data}),
        .data_o  (mg_data)
    );

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        unique case (1'b1)
            rmw_act: begin
                mem_addr  = waddr_q;
                mem_we    = 1'b1;
                mem_wdata = mg_data;
            end
            (acc && !bad): begin
                mem_addr = sel_addr[AW+1:2];
                if (sel_we && sel_size == SZ_WORD) begin
                    mem_we    = 1'b1;
                    mem_wdata = sel_wdata;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        rmw_d    = rmw_q;
        waddr_d  = waddr_q;
        rsp_v    = 1'b0;
        rsp_b    = 1'b0;
        rsp_err  = 1'b0;
        rsp_data = '0;
        if (state_q == ST_RMW_WR) begin
            state_d = ST_IDLE;
            rsp_v   = 1'b1;
            rsp_b   = rmw_q.port_b;
        end else if (acc) begin
            ptr_d = b_gnt;
            rsp_b = b_gnt;
            if (bad) begin
                rsp_v   = 1'b1;
                rsp_err = 1'b1;
            end else if (is_sub) begin
                state_d      = ST_RMW_WR;
                rmw_d.old    = mem_rdata;
                rmw_d.lane   = sel_addr[1:0];
                rmw_d.size   = sel_size;
                rmw_d.data   = sel_wdata[15:0];
                rmw_d.port_b = b_gnt;
                waddr_d      = sel_addr[AW+1:2];
            end else begin
                rsp_v    = 1'b1;
                rsp_data = sel_we ? 32'h0 : ld_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 1'b1;
            rmw_q      <= '0;
            waddr_q    <= '0;
            a_rvalid_q <= 1'b0;
            a_err_q    <= 1'b0;
            a_rdata_q  <= '0;
            b_rvalid_q <= 1'b0;
            b_err_q    <= 1'b0;
            b_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rmw_q      <= rmw_d;
            waddr_q    <= waddr_d;
            a_rvalid_q <= rsp_v && !rsp_b;
            a_err_q    <= rsp_v && !rsp_b && rsp_err;
            b_rvalid_q <= rsp_v && rsp_b;
            b_err_q    <= rsp_v && rsp_b && rsp_err;
            if (rsp_v && !rsp_b) begin
                a_rdata_q <= rsp_data;
            end
            if (rsp_v && rsp_b) begin
                b_rdata_q <= rsp_data;
            end
        end
    end

    assign a_rvalid = a_rvalid_q;
    assign a_err    = a_err_q;
    assign a_rdata  = a_rdata_q;
    assign b_rvalid = b_rvalid_q;
    assign b_err    = b_err_q;
    assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl with a behavioural memory model.
// Drivers queue expected responses and writes; a monitor checks them.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req, a_we, a_unsigned;
    logic [1:0]  a_size;
    logic [31:0] a_addr, a_wdata;
    logic        a_gnt, a_rvalid, a_err;
    logic [31:0] a_rdata;
    logic        b_req, b_we;
    logic [31:0] b_addr, b_wdata;
    logic        b_gnt, b_rvalid, b_err;
    logic [31:0] b_rdata;
    logic [8:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_ctrl #(.DEPTH(512), .AW(9)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_size(a_size),
        .a_unsigned(a_unsigned), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Physical memory seen by the DUT
    logic [31:0] mem [512];
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    // Reference contents, updated in request order at accept time
    logic [31:0] ref_mem [512];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail = 0;

    typedef struct { int cyc; bit err; logic [31:0] data; } rsp_t;
    typedef struct { int cyc; int idx; logic [31:0] data; } wr_t;
    typedef struct { bit pb; int cyc; } g_t;
    rsp_t aq[$], bq[$];
    wr_t  wq[$];
    g_t   glog[$];

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] ext(logic [31:0] w, int sh, logic [1:0] sz, logic uns);
        logic [31:0] v;
        v = w >> sh;
        if (sz == 2'd0) begin
            v = v & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = v & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic void accept(bit pb, logic we, logic [1:0] sz, logic uns,
                                   logic [31:0] addr, logic [31:0] wd);
        rsp_t r;
        wr_t w;
        g_t g;
        int idx, sh;
        logic [31:0] m, old;
        bit bad;
        bad = (sz == 2'd3) || (sz == 2'd1 && addr[0])
           || (sz == 2'd2 && addr[1:0] != 2'd0) || (addr >= 32'd2048);
        idx = int'(addr[10:2]);
        sh = 8 * int'(addr[1:0]);
        r.cyc = cyc + 1;
        r.err = bad;
        r.data = 32'h0;
        g.pb = pb;
        g.cyc = cyc;
        glog.push_back(g);
        if (!bad) begin
            old = ref_mem[idx];
            if (!we) begin
                r.data = ext(old, sh, sz, uns);
            end else if (sz == 2'd2) begin
                ref_mem[idx] = wd;
                w.cyc = cyc; w.idx = idx; w.data = wd;
                wq.push_back(w);
            end else begin
                m = (sz == 2'd0 ? 32'hFF : 32'hFFFF) << sh;
                ref_mem[idx] = (old & ~m) | ((wd << sh) & m);
                w.cyc = cyc + 1; w.idx = idx; w.data = ref_mem[idx];
                wq.push_back(w);
                r.cyc = cyc + 2;
            end
        end
        if (pb) bq.push_back(r);
        else aq.push_back(r);
    endfunction

    task automatic a_op(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, output int waits);
        int n = 0;
        a_req = 1'b1; a_we = we; a_size = sz; a_unsigned = uns;
        a_addr = addr; a_wdata = wd;
        do begin
            @(negedge clk);
            n++;
        end while (!a_gnt && n < 50);
        waits = n;
        if (!a_gnt) chk("a_gnt_timeout", 0, 1);
        else accept(1'b0, we, sz, uns, addr, wd);
        @(posedge clk);
        #1;
        a_req = 1'b0;
    endtask

    task automatic b_op(input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, output int waits);
        int n = 0;
        b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
        do begin
            @(negedge clk);
            n++;
        end while (!b_gnt && n < 50);
        waits = n;
        if (!b_gnt) chk("b_gnt_timeout", 0, 1);
        else accept(1'b1, we, SZ_WORD, 1'b0, addr, wd);
        @(posedge clk);
        #1;
        b_req = 1'b0;
    endtask

    // Monitor: sampled just after the falling edge, once drivers have queued
    rsp_t mr;
    wr_t  mw;
    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            if (a_gnt && b_gnt) chk("double_gnt", 1, 0);
            if (a_rvalid) begin
                if (aq.size() == 0) chk("a_unexpected_rvalid", 1, 0);
                else begin
                    mr = aq.pop_front();
                    chk("a_rv_cycle", 64'(cyc), 64'(mr.cyc));
                    chk("a_err", 64'(a_err), 64'(mr.err));
                    chk("a_rdata", 64'(a_rdata), 64'(mr.data));
                end
            end else if (aq.size() != 0 && aq[0].cyc <= cyc) begin
                mr = aq.pop_front();
                chk("a_missing_rvalid", 64'(cyc), 64'(mr.cyc));
            end
            if (b_rvalid) begin
                if (bq.size() == 0) chk("b_unexpected_rvalid", 1, 0);
                else begin
                    mr = bq.pop_front();
                    chk("b_rv_cycle", 64'(cyc), 64'(mr.cyc));
                    chk("b_err", 64'(b_err), 64'(mr.err));
                    chk("b_rdata", 64'(b_rdata), 64'(mr.data));
                end
            end else if (bq.size() != 0 && bq[0].cyc <= cyc) begin
                mr = bq.pop_front();
                chk("b_missing_rvalid", 64'(cyc), 64'(mr.cyc));
            end
            if (mem_we) begin
                if (wq.size() == 0) chk("unexpected_mem_we", 1, 0);
                else begin
                    mw = wq.pop_front();
                    chk("mem_we_cycle", 64'(cyc), 64'(mw.cyc));
                    chk("mem_addr", 64'(mem_addr), 64'(mw.idx));
                    chk("mem_wdata", 64'(mem_wdata), 64'(mw.data));
                end
            end else if (wq.size() != 0 && wq[0].cyc <= cyc) begin
                mw = wq.pop_front();
                chk("missing_mem_we", 64'(cyc), 64'(mw.cyc));
            end
        end
    end

    task automatic rand_a(output logic [1:0] sz, output logic [31:0] addr);
        sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 2047));
        if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'd1) addr[0] = 1'b0;
            if (sz == 2'd2) addr[1:0] = 2'b00;
        end
    endtask

    int w;
    bit saw;

    initial begin
        for (int i = 0; i < 512; i++) begin
            ref_mem[i] = $urandom;
            mem[i] <= ref_mem[i];
        end
        ref_mem[3] = 32'h80FF7F01;
        mem[3] <= 32'h80FF7F01;
        // Requests held during reset must not leak through
        a_req = 1'b1; a_we = 1'b1; a_size = SZ_WORD; a_unsigned = 1'b0;
        a_addr = 32'h10; a_wdata = 32'hDEADBEEF;
        b_req = 1'b1; b_we = 1'b1; b_addr = 32'h20; b_wdata = 32'h12345678;
        repeat (2) @(negedge clk);
        chk("rst_a_gnt", a_gnt, 0);
        chk("rst_b_gnt", b_gnt, 0);
        chk("rst_a_rvalid", a_rvalid, 0);
        chk("rst_b_rvalid", b_rvalid, 0);
        chk("rst_a_err", a_err, 0);
        chk("rst_b_err", b_err, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_b_rdata", b_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        a_req = 1'b0; b_req = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Sub-word loads from word 0x0C = 0x80FF7F01
        a_op(1'b0, SZ_BYTE, 1'b0, 32'h0E, 32'h0, w);
        a_op(1'b0, SZ_BYTE, 1'b1, 32'h0F, 32'h0, w);
        a_op(1'b0, SZ_HALF, 1'b0, 32'h0C, 32'h0, w);

        // Byte store followed by word read of the same word
        a_op(1'b1, SZ_BYTE, 1'b0, 32'h0D, 32'hAA, w);
        a_op(1'b0, SZ_WORD, 1'b0, 32'h0C, 32'h0, w);

        // Errors: no write may appear
        a_op(1'b0, SZ_HALF, 1'b0, 32'h03, 32'h0, w);
        a_op(1'b0, SZ_WORD, 1'b0, 32'h02, 32'h0, w);
        a_op(1'b1, SZ_ILL, 1'b0, 32'h00, 32'hFFFFFFFF, w);
        a_op(1'b0, SZ_WORD, 1'b0, 32'h800, 32'h0, w);
        a_op(1'b1, SZ_WORD, 1'b0, 32'h800, 32'h55, w);
        a_op(1'b0, SZ_WORD, 1'b0, 32'h00, 32'h0, w);

        // Continuous contention
        repeat (2) @(posedge clk);
        #1;
        glog.delete();
        fork
            begin
                int wa;
                for (int i = 0; i < 6; i++) a_op(1'b0, SZ_WORD, 1'b0, 32'(i * 4), 0, wa);
            end
            begin
                int wb;
                for (int i = 0; i < 6; i++) b_op(1'b0, 32'(64 + i * 4), 0, wb);
            end
        join
        chk("arb_count", glog.size(), 12);
        for (int i = 1; i < glog.size(); i++) begin
            chk("arb_alternate", 64'(glog[i].pb ^ glog[i-1].pb), 1);
            chk("arb_back_to_back", 64'(glog[i].cyc - glog[i-1].cyc), 1);
        end
        repeat (2) @(posedge clk);
        #1;
        b_op(1'b0, 32'h20, 32'h0, w);
        chk("b_lone_gnt_wait", w, 1);

        // Fill all words from B while A waits for a slot
        fork
            begin
                int wb;
                for (int i = 0; i < 512; i++) b_op(1'b1, 32'(i * 4), $urandom, wb);
            end
            begin
                int wa;
                repeat (30) @(posedge clk);
                #1;
                a_op(1'b0, SZ_WORD, 1'b0, 32'h40, 0, wa);
                chk("a_pending_wait", 64'(wa <= 2), 1);
            end
        join
        for (int i = 0; i < 512; i++) b_op(1'b0, 32'(i * 4), 0, w);

        // Randomised mix on both ports
        fork
            begin
                logic [1:0]  sz;
                logic [31:0] ad;
                int wa;
                for (int i = 0; i < 200; i++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    rand_a(sz, ad);
                    a_op(1'($urandom), sz, 1'($urandom), ad, $urandom, wa);
                end
            end
            begin
                logic [31:0] ad;
                int wb;
                for (int i = 0; i < 100; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                    ad = 32'($urandom_range(0, 2047));
                    if ($urandom_range(0, 5) != 0) ad[1:0] = 2'b00;
                    if ($urandom_range(0, 15) == 0) ad = 32'h800 + ad;
                    b_op(1'($urandom), ad, $urandom, wb);
                end
            end
        join

        // Reset landing in the write half of a halfword store
        repeat (3) @(posedge clk);
        #1;
        a_req = 1'b1; a_we = 1'b1; a_size = SZ_HALF; a_unsigned = 1'b0;
        a_addr = 32'h12; a_wdata = 32'h1234;
        @(negedge clk);
        chk("rmw_gnt", a_gnt, 1);
        @(posedge clk);
        #1;
        a_req = 1'b0;
        chk("rmw_we_pending", mem_we, 1);
        rst = 1'b1;
        #1;
        chk("rmw_rst_mem_we", mem_we, 0);
        chk("rmw_rst_mem_addr", mem_addr, 0);
        chk("rmw_rst_mem_wdata", mem_wdata, 0);
        chk("rmw_rst_a_gnt", a_gnt, 0);
        chk("rmw_rst_a_rvalid", a_rvalid, 0);
        chk("rmw_rst_a_rdata", a_rdata, 0);
        chk("rmw_rst_b_rdata", b_rdata, 0);
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (a_rvalid) saw = 1'b1;
        end
        chk("rmw_rst_no_rvalid", saw, 0);
        @(posedge clk);
        #1;
        a_op(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, w);
        chk("post_rst_idle_gnt", w, 1);

        repeat (4) @(negedge clk);
        chk("a_queue_drained", aq.size(), 0);
        chk("b_queue_drained", bq.size(), 0);
        chk("w_queue_drained", wq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Sequencer and arbiter in front of the 512×32 word-addressed data memory. The memory has a combinational read and a synchronous write, with no byte enables. The block shares that memory between the CPU load/store port (A) and the debug/loader port (B). It converts byte addresses to word indices, performs sign/zero-extended sub-word loads, and turns byte/halfword stores into a two-cycle read-modify-write. Misaligned, out-of-range and illegal-size accesses are rejected with an error response and no memory access.

## Interface
Parameters:
- DEPTH, 512, number of 32-bit words; legal byte addresses are 0 .. DEPTH*4-1.
- AW, 9, word-index width (clog2(DEPTH)).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- a_req  in  1  CPU request
- a_we  in  1  1=store, 0=load
- a_size  in  2  0=byte, 1=half, 2=word, 3=illegal
- a_unsigned  in  1  zero-extend sub-word loads
- a_addr  in  32  byte address
- a_wdata  in  32  store data, right-aligned
- a_gnt  out  1  request accepted, one-cycle pulse
- a_rvalid  out  1  completion, one-cycle pulse
- a_rdata  out  32  extended load data; 0 for stores and errors
- a_err  out  1  valid with a_rvalid
- b_req, b_we, b_addr[31:0], b_wdata[31:0]  in  word-only debug request
- b_gnt, b_rvalid, b_err  out  1; b_rdata  out  32  debug response
- mem_addr  out  AW  word index to memory
- mem_we  out  1  memory write enable
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data (combinational from mem_addr)

## Operation
- FSM states: IDLE, RMW_WR.
- Requests are accepted only in IDLE.
- Arbitration is round-robin on a 1-bit last-grant pointer. The pointer is reset to B, so A wins the first tie. A lone requester always wins.
- Requester holds req and its fields stable until gnt. Fields are ignored after gnt.
- Error checks, evaluated at accept:
  - size==3, or B size≠word (B is implicitly word).
  - half with addr[0]≠0, or word with addr[1:0]≠0.
  - addr ≥ DEPTH*4.
- On error: gnt is given, there is no memory access, and an err response follows.
- Load: mem_addr=addr[AW+1:2] in the accept cycle. The lane is selected by addr[1:0] and extended per a_unsigned. The result is registered into rdata.
- Word store: mem_we=1, mem_wdata=wdata in the accept cycle.
- Sub-word store, accept cycle: the old word is latched into a merge buffer along with lane/size/data, then go to RMW_WR.
- RMW_WR: mem_we=1, mem_wdata=buffer with the target byte/half replaced, same mem_addr; then return to IDLE.
- mem_we is only ever asserted in the accept cycle of a word store or in RMW_WR.

## Timing
- Load / word store / error, accepted at cycle T: gnt at T, rvalid at T+1. Next accept is possible at T+1.
- Sub-word store accepted at T: read at T, write at T+1, rvalid at T+2. There is no gnt at T+1, and the next accept is possible at T+2.
- rvalid of one request and gnt of the next may coincide.
- Write-then-read of the same word on consecutive accepts returns the new data, because the memory write lands at the clock edge before the read.
- Reset values:
  - All gnt/rvalid/err/mem_we = 0.
  - rdata = 0, mem_addr = 0, mem_wdata = 0.
  - State = IDLE, pointer = B.
- Reset asserted in RMW_WR: mem_we drops immediately and the write is lost. No rvalid is issued for that request.

## Structure
- dmem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - state enum.
  - DEPTH default.
- One sub-module, dmem_lane: purely combinational.
  - extract(word, lane, size, unsigned) for loads.
  - merge(word, lane, size, data) for stores.
  - Instantiated once for the load path and once for the RMW path.

## Test plan
- Word 0x0000000C holds 0x80FF_7F01. A lb from byte 0x0E returns 0xFFFFFFFF; lbu from 0x0F returns 0x00000080; lh from 0x0C returns 0x00007F01. Each rvalid arrives at T+1.
- sb 0xAA to byte 0x0D, then lw from 0x0C. Required: mem_we only at T+1, read data 0x80FF_AA01, sb rvalid at T+2.
- Both ports request continuously with loads. Required: grants alternate A,B,A,B, each gnt one cycle apart; a lone B request is granted immediately.
- lh at 0x03, lw at 0x02, size=3, and lw at 0x800. Required: err=1 with rvalid at T+1, mem_we never asserted, memory unchanged.
- B word stores at 0x000..0x7FC, then reads return identical data. Meanwhile a pending A request is granted within 2 accepts.
- rst asserted during RMW_WR of sh 0x1234 to 0x12. Required: no rvalid, all outputs 0 in the same cycle, FSM in IDLE afterwards.
